meta_pkt_parser: RTL and testbench
==================================

Name: meta_pkt_parser

Overview:
Downstream stage of the 8→32 byte-assembly DMA. Consumes the 32-bit metadata word stream and frames it into packets: header word, N payload words, checksum word. Forwards payload words with type and last markers to meta_decode. Validates magic, length and checksum, and reports per-packet status plus running counters.

Parameters:
MAGIC, 8'hA5, required value of header[31:24]
MAX_WORDS, 1024, largest legal payload length in words
CNT_W, 16, width of the packet and error counters

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
in_data  in  32  input word from the byte assembler
in_valid  in  1  input word valid
in_ready  out  1  input word accepted when in_valid && in_ready
cfg_enable  in  1  allows a new header to be accepted
pl_data  out  32  payload word
pl_valid  out  1  payload word valid
pl_ready  in  1  downstream ready
pl_last  out  1  marks the final payload word of a packet
pl_type  out  8  header[23:16] of the current packet
pkt_done  out  1  1-cycle pulse when a checksum word has been evaluated
pkt_ok  out  1  1-cycle pulse, checksum matched (coincides with pkt_done)
err_magic  out  1  1-cycle pulse, bad magic
err_len  out  1  1-cycle pulse, illegal length
err_csum  out  1  1-cycle pulse, checksum mismatch (coincides with pkt_done)
pkt_count  out  CNT_W  good packets, saturating
err_count  out  CNT_W  errors of any kind, saturating
busy  out  1  state != IDLE or pl_valid

Behaviour:
- Reset (rst_n low at a clk edge, synchronous):
  - state=IDLE.
  - pl_valid, pl_last, pl_data, pl_type, all pulses, pkt_count, err_count and the checksum accumulator all clear to 0.
  - Takes priority over everything, including mid-packet; the partial packet is dropped with no status pulse.
- Header format: [31:24] magic, [23:16] type, [15:0] length N in words.
- Checksum word = 32-bit wrapping sum of the header word and all N payload words.
- States:
  - IDLE:
    - in_ready=cfg_enable.
    - On header accept, set acc=header and latch N and type.
    - magic!=MAGIC → err_magic pulse, stay IDLE (resync on the next word).
    - N==0 or N>MAX_WORDS → err_len pulse, stay IDLE.
    - Otherwise go to PAYLOAD with remaining=N.
  - PAYLOAD:
    - in_ready = !pl_valid || pl_ready (one-entry output register, full throughput).
    - On accept: the word loads into pl_data on the next edge with pl_valid=1; acc += word; remaining decrements.
    - pl_last=1 when the loaded word had remaining==1; the state then moves to CSUM.
  - CSUM:
    - in_ready=1, independent of the output register.
    - On accept, compare in_data with acc.
    - Next cycle: pkt_done=1, plus pkt_ok=1 on a match or err_csum=1 on a mismatch.
    - Return to IDLE.
- Latency: input accept → pl_valid is 1 cycle. Checksum accept → pkt_done is 1 cycle.
- Output register:
  - pl_data, pl_last and pl_type hold stable while pl_valid && !pl_ready.
  - pl_valid clears when pl_ready is high and no new word is loaded.
  - A simultaneous drain and load keeps pl_valid=1 with the new data.
- The next header may be accepted in IDLE while the last payload word is still held. PAYLOAD then stalls until that word drains.
- Payload is forwarded before the checksum is known. Downstream uses pkt_ok or err_csum to commit or discard the packet.
- cfg_enable is sampled only in IDLE. Deasserting it mid-packet does not abort the packet.
- Counters:
  - pkt_count increments on pkt_ok.
  - err_count increments on any err_* pulse; at most one error pulse occurs per cycle.
  - Both counters saturate at all-ones.
- The remaining-word counter is 16 bits wide. acc wraps modulo 2^32.

Decomposition:
- Package meta_pkt_pkg holds:
  - the state enum (IDLE, PAYLOAD, CSUM);
  - header field positions: MAGIC_HI=31, MAGIC_LO=24, TYPE_HI=23, TYPE_LO=16, LEN_HI=15, LEN_LO=0;
  - the default MAGIC.
- No sub-module: the output register, accumulator and FSM stay in one module of roughly 200 lines.

Test Plan:
- Good packet: A5010003, 1, 2, 3, A5010009 with pl_ready=1 → pl_data 1, 2, 3 with pl_last on 3 and pl_type=01; pkt_done+pkt_ok; pkt_count=1, err_count=0.
- Bad checksum: same packet but checksum A5010008 → payload 1, 2, 3 still forwarded; pkt_done+err_csum; err_count=1.
- Bad magic 5A010003 followed by the good packet → err_magic pulse; the good packet then parses with pkt_ok and pkt_count=1.
- Illegal length:
  - A5020000 → err_len.
  - A5020401 → err_len.
  - Then a good packet → ok; err_count=2.
- Backpressure: pl_ready low for 5 cycles mid-payload → pl_data stable, in_ready=0, no word lost or duplicated; then pl_ready toggling every cycle → words arrive in order.
- Reset mid-payload after 2 of 3 words → pl_valid=0, counters 0, IDLE; the next good packet parses correctly.

Source files
------------

// File: rtl/meta_pkt_pkg.sv
`default_nettype none
// ============================================================================
// Package : meta_pkt_pkg
// Purpose : Shared types and constants for the metadata packet parser.
//           Holds the parser state encoding, header field bit positions and
//           the default header magic byte.
// Rev     : 1.0  initial release
// ============================================================================
package meta_pkt_pkg;

  // Parser states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    CSUM    = 2'd2
  } state_e;

  // Header word field positions
  localparam int MAGIC_HI = 31;
  localparam int MAGIC_LO = 24;
  localparam int TYPE_HI  = 23;
  localparam int TYPE_LO  = 16;
  localparam int LEN_HI   = 15;
  localparam int LEN_LO   = 0;

  // Default header magic byte
  localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;

endpackage : meta_pkt_pkg
`default_nettype wire

// File: rtl/meta_pkt_parser.sv
`default_nettype none
// ============================================================================
// Module  : meta_pkt_parser
// Purpose : Frames the 32-bit metadata word stream into packets
//           (header, N payload words, checksum word), forwards payload words
//           with type/last markers through a one-entry output register, and
//           validates magic, length and checksum.
// Ports   :
//   clk, rst_n              clock, synchronous active-low reset
//   in_data/valid/ready     input word stream from the byte assembler
//   cfg_enable              allows a new header to be accepted
//   pl_data/valid/ready     payload output stream
//   pl_last, pl_type        final-word marker, packet type of held word
//   pkt_done, pkt_ok        checksum evaluated / matched (1-cycle pulses)
//   err_magic/len/csum      error pulses (1 cycle each)
//   pkt_count, err_count    saturating good-packet / error counters
//   busy                    parser not idle or output word still held
// Rev     : 1.0  initial release
// ============================================================================
module meta_pkt_parser
  import meta_pkt_pkg::*;
#(
  parameter logic [7:0] MAGIC     = MAGIC_DEFAULT,
  parameter int         MAX_WORDS = 1024,
  parameter int         CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             cfg_enable,
  output logic [31:0]      pl_data,
  output logic             pl_valid,
  input  logic             pl_ready,
  output logic             pl_last,
  output logic [7:0]       pl_type,
  output logic             pkt_done,
  output logic             pkt_ok,
  output logic             err_magic,
  output logic             err_len,
  output logic             err_csum,
  output logic [CNT_W-1:0] pkt_count,
  output logic [CNT_W-1:0] err_count,
  output logic             busy
);

  state_e             state_q, state_d;
  logic [31:0]        acc_q, acc_d;
  logic [15:0]        rem_q, rem_d;
  logic [7:0]         type_q, type_d;

  logic [31:0]        pl_data_q, pl_data_d;
  logic               pl_valid_q, pl_valid_d;
  logic               pl_last_q, pl_last_d;
  logic [7:0]         pl_type_q, pl_type_d;

  logic               done_q, done_d;
  logic               ok_q, ok_d;
  logic               emagic_q, emagic_d;
  logic               elen_q, elen_d;
  logic               ecsum_q, ecsum_d;

  logic [CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic               in_ready_w;
  logic               accept_w;
  logic [7:0]         hdr_magic_w;
  logic [15:0]        hdr_len_w;

  assign hdr_magic_w = in_data[MAGIC_HI:MAGIC_LO];
  assign hdr_len_w   = in_data[LEN_HI:LEN_LO];
  assign accept_w    = in_valid && in_ready_w;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    rem_d      = rem_q;
    type_d     = type_q;
    pl_data_d  = pl_data_q;
    pl_valid_d = pl_valid_q;
    pl_last_d  = pl_last_q;
    pl_type_d  = pl_type_q;
    done_d     = 1'b0;
    ok_d       = 1'b0;
    emagic_d   = 1'b0;
    elen_d     = 1'b0;
    ecsum_d    = 1'b0;
    in_ready_w = 1'b0;

    // Drain of the held word; a load below overrides this in the same cycle.
    if (pl_valid_q && pl_ready) begin
      pl_valid_d = 1'b0;
      pl_last_d  = 1'b0;
    end

    case (state_q)
      IDLE: begin
        in_ready_w = cfg_enable;
        if (accept_w) begin
          acc_d  = in_data;
          type_d = in_data[TYPE_HI:TYPE_LO];
          if (hdr_magic_w != MAGIC) begin
            emagic_d = 1'b1;
          end else if ((hdr_len_w == 16'd0) ||
                       ({16'd0, hdr_len_w} > 32'(MAX_WORDS))) begin
            elen_d = 1'b1;
          end else begin
            rem_d   = hdr_len_w;
            state_d = PAYLOAD;
          end
        end
      end

      PAYLOAD: begin
        // One-entry output register: accept whenever it is empty or draining.
        in_ready_w = !pl_valid_q || pl_ready;
        if (accept_w) begin
          pl_data_d  = in_data;
          pl_valid_d = 1'b1;
          pl_last_d  = (rem_q == 16'd1);
          // Type comes from the latched header so a following header accepted
          // while this word is held cannot disturb it.
          pl_type_d  = type_q;
          acc_d      = acc_q + in_data;
          rem_d      = rem_q - 16'd1;
          if (rem_q == 16'd1) begin
            state_d = CSUM;
          end
        end
      end

      CSUM: begin
        in_ready_w = 1'b1;
        if (accept_w) begin
          done_d  = 1'b1;
          ok_d    = (in_data == acc_q);
          ecsum_d = (in_data != acc_q);
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    pkt_cnt_d = pkt_cnt_q;
    if (ok_d && (pkt_cnt_q != {CNT_W{1'b1}})) begin
      pkt_cnt_d = pkt_cnt_q + 1'b1;
    end

    // At most one error source can fire per cycle, so a single increment.
    err_cnt_d = err_cnt_q;
    if ((emagic_d || elen_d || ecsum_d) && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      rem_q      <= '0;
      type_q     <= '0;
      pl_data_q  <= '0;
      pl_valid_q <= 1'b0;
      pl_last_q  <= 1'b0;
      pl_type_q  <= '0;
      done_q     <= 1'b0;
      ok_q       <= 1'b0;
      emagic_q   <= 1'b0;
      elen_q     <= 1'b0;
      ecsum_q    <= 1'b0;
      pkt_cnt_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      rem_q      <= rem_d;
      type_q     <= type_d;
      pl_data_q  <= pl_data_d;
      pl_valid_q <= pl_valid_d;
      pl_last_q  <= pl_last_d;
      pl_type_q  <= pl_type_d;
      done_q     <= done_d;
      ok_q       <= ok_d;
      emagic_q   <= emagic_d;
      elen_q     <= elen_d;
      ecsum_q    <= ecsum_d;
      pkt_cnt_q  <= pkt_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign in_ready  = in_ready_w;
  assign pl_data   = pl_data_q;
  assign pl_valid  = pl_valid_q;
  assign pl_last   = pl_last_q;
  assign pl_type   = pl_type_q;
  assign pkt_done  = done_q;
  assign pkt_ok    = ok_q;
  assign err_magic = emagic_q;
  assign err_len   = elen_q;
  assign err_csum  = ecsum_q;
  assign pkt_count = pkt_cnt_q;
  assign err_count = err_cnt_q;
  assign busy      = (state_q != IDLE) || pl_valid_q;

endmodule : meta_pkt_parser
`default_nettype wire

// File: tb/tb_meta_pkt_parser.sv
`default_nettype none
// ============================================================================
// Module  : tb_meta_pkt_parser
// Purpose : Directed self-checking bench for meta_pkt_parser.
// Rev     : 1.0  initial release
// ============================================================================
module tb_meta_pkt_parser;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        cfg_enable;
  logic [31:0] pl_data;
  logic        pl_valid;
  logic        pl_ready;
  logic        pl_last;
  logic [7:0]  pl_type;
  logic        pkt_done;
  logic        pkt_ok;
  logic        err_magic;
  logic        err_len;
  logic        err_csum;
  logic [15:0] pkt_count;
  logic [15:0] err_count;
  logic        busy;

  meta_pkt_parser dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .cfg_enable (cfg_enable),
    .pl_data    (pl_data),
    .pl_valid   (pl_valid),
    .pl_ready   (pl_ready),
    .pl_last    (pl_last),
    .pl_type    (pl_type),
    .pkt_done   (pkt_done),
    .pkt_ok     (pkt_ok),
    .err_magic  (err_magic),
    .err_len    (err_len),
    .err_csum   (err_csum),
    .pkt_count  (pkt_count),
    .err_count  (err_count),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
    logic [7:0]  t;
  } beat_t;

  beat_t       got_q[$];
  logic [31:0] exp_q[$];
  int          n_done, n_ok, n_csum, n_magic, n_len;
  int          n_checks = 0;
  int          n_fail   = 0;

  // Observe outputs late in the low phase, one sample per clock.
  always @(negedge clk) begin
    #4;
    if (pl_valid && pl_ready) got_q.push_back('{d: pl_data, l: pl_last, t: pl_type});
    if (pkt_done)  n_done++;
    if (pkt_ok)    n_ok++;
    if (err_csum)  n_csum++;
    if (err_magic) n_magic++;
    if (err_len)   n_len++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clr_mon();
    got_q.delete();
    exp_q.delete();
    n_done = 0; n_ok = 0; n_csum = 0; n_magic = 0; n_len = 0;
  endtask

  // Presents one word and returns at the negedge after it was accepted.
  task automatic send(input logic [31:0] w);
    int n = 0;
    in_data  = w;
    in_valid = 1'b1;
    #1;
    while (!in_ready && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 60) check_val("send_timeout", 32'(n), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic check_stream(input string tag, input logic [7:0] t);
    int n;
    check_val({tag, "_nbeats"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check_val({tag, "_data"}, got_q[i].d, exp_q[i]);
      check_val({tag, "_last"}, 32'(got_q[i].l), 32'(i == exp_q.size() - 1));
      check_val({tag, "_type"}, 32'(got_q[i].t), 32'(t));
    end
  endtask

  task automatic check_status(input string tag, input int done, input int ok, input int csum,
                              input int mag, input int len, input int pc, input int ec);
    check_val({tag, "_done"},  32'(n_done),  32'(done));
    check_val({tag, "_ok"},    32'(n_ok),    32'(ok));
    check_val({tag, "_csum"},  32'(n_csum),  32'(csum));
    check_val({tag, "_magic"}, 32'(n_magic), 32'(mag));
    check_val({tag, "_len"},   32'(n_len),   32'(len));
    check_val({tag, "_pktcnt"}, 32'(pkt_count), 32'(pc));
    check_val({tag, "_errcnt"}, 32'(err_count), 32'(ec));
  endtask

  task automatic send_good();
    send(32'hA501_0003); send(32'd1); send(32'd2); send(32'd3); send(32'hA501_0009);
  endtask

  initial begin
    rst_n = 1'b0; in_data = '0; in_valid = 1'b0; cfg_enable = 1'b1; pl_ready = 1'b1;
    clr_mon();
    idle(3);
    rst_n = 1'b1;
    idle(1);

    // Reset state
    check_val("rst_pl_valid", 32'(pl_valid), 32'd0);
    check_val("rst_pl_data",  pl_data,       32'd0);
    check_val("rst_busy",     32'(busy),     32'd0);
    check_val("rst_in_ready", 32'(in_ready), 32'd1);
    check_status("rst", 0, 0, 0, 0, 0, 0, 0);

    // cfg_enable low holds off header acceptance in IDLE
    cfg_enable = 1'b0;
    #1;
    check_val("cfg_off_ready", 32'(in_ready), 32'd0);
    cfg_enable = 1'b1;

    // Good packet
    clr_mon();
    send_good();
    idle(3);
    exp_q = '{32'd1, 32'd2, 32'd3};
    check_stream("good", 8'h01);
    check_status("good", 1, 1, 0, 0, 0, 1, 0);

    // Bad checksum: payload still forwarded
    clr_mon();
    send(32'hA501_0003); send(32'd1); send(32'd2); send(32'd3); send(32'hA501_0008);
    idle(3);
    exp_q = '{32'd1, 32'd2, 32'd3};
    check_stream("badcs", 8'h01);
    check_status("badcs", 1, 0, 1, 0, 0, 1, 1);

    // Bad magic, then resync on a good packet
    clr_mon();
    send(32'h5A01_0003);
    send_good();
    idle(3);
    exp_q = '{32'd1, 32'd2, 32'd3};
    check_stream("magic", 8'h01);
    check_status("magic", 1, 1, 0, 1, 0, 2, 2);

    // Illegal lengths (0 and 1025), then a good packet
    clr_mon();
    send(32'hA502_0000);
    send(32'hA502_0401);
    send_good();
    idle(3);
    exp_q = '{32'd1, 32'd2, 32'd3};
    check_stream("len", 8'h01);
    check_status("len", 1, 1, 0, 0, 2, 3, 4);

    // Backpressure: stall 5 cycles, then ready toggling every cycle
    clr_mon();
    pl_ready = 1'b0;
    send(32'hA503_0004);
    send(32'h0000_000A);
    in_data = 32'h0000_0014; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      idle(1);
      check_val("bp_hold_data",  pl_data,        32'h0000_000A);
      check_val("bp_hold_valid", 32'(pl_valid),  32'd1);
      check_val("bp_in_ready",   32'(in_ready),  32'd0);
    end
    fork
      begin
        send(32'h0000_0014); send(32'h0000_001E); send(32'h0000_0028); send(32'hA503_0068);
      end
      begin
        repeat (16) begin
          @(negedge clk);
          pl_ready = ~pl_ready;
        end
        pl_ready = 1'b1;
      end
    join
    idle(4);
    exp_q = '{32'h0A, 32'h14, 32'h1E, 32'h28};
    check_stream("bp", 8'h03);
    check_status("bp", 1, 1, 0, 0, 0, 4, 4);

    // Reset mid-payload with the second word held in the output register
    clr_mon();
    send(32'hA501_0003); send(32'd1); send(32'd2);
    pl_ready = 1'b0;
    idle(1);
    check_val("pre_rst_valid", 32'(pl_valid), 32'd1);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    check_val("mid_rst_valid",  32'(pl_valid),  32'd0);
    check_val("mid_rst_busy",   32'(busy),      32'd0);
    check_val("mid_rst_pktcnt", 32'(pkt_count), 32'd0);
    check_val("mid_rst_errcnt", 32'(err_count), 32'd0);
    pl_ready = 1'b1;
    idle(1);
    clr_mon();
    send_good();
    idle(3);
    exp_q = '{32'd1, 32'd2, 32'd3};
    check_stream("postrst", 8'h01);
    check_status("postrst", 1, 1, 0, 0, 0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0t exp=finish", $time);
    $fatal(1, "timeout");
  end

endmodule : tb_meta_pkt_parser
`default_nettype wire
